// File: rtl/seg_pkg.sv
// Shared types, constants and helpers for the seven-segment scan driver.
package seg_pkg;

  localparam int unsigned NDIG  = 8;
  localparam int unsigned DIG_W = 3;
  localparam int unsigned SEG_W = 8;

  localparam logic [SEG_W-1:0] SEG_DARK = 8'hFF;
  localparam logic [SEG_W-1:0] AN_OFF   = 8'hFF;
  localparam logic [DIG_W-1:0] DIG_LAST = 3'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SHOW = 2'd2
  } scan_state_e;

  // Registered display outputs, updated together every cycle.
  typedef struct packed {
    logic [SEG_W-1:0] seg;
    logic [SEG_W-1:0] an;
    logic             frame;
  } scan_out_t;

  // Active-low one-hot digit select for digit d.
  function automatic logic [SEG_W-1:0] an_onehot(input logic [DIG_W-1:0] d);
    return ~(8'b1 << d);
  endfunction

endpackage

// File: rtl/seg_scan_slot_cnt.sv
// Per-digit slot counter: counts 0..CLK_DIV-1 while advancing, flags the last slot cycle.
module seg_slot_cnt #(
  parameter int unsigned CLK_DIV = 1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clr,
  input  logic                       i_adv,
  output logic [$clog2(CLK_DIV)-1:0] o_cnt,
  output logic                       o_slot_end
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_slot_end;
  logic [CW-1:0] w_cnt_nxt;

  // Next count: clear wins, otherwise wrap at the end of the slot.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (i_adv) begin
      w_cnt_nxt = r_slot_end ? '0 : r_cnt + CW'(1);
    end
  end

  // Count and end-of-slot flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_slot_end <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_slot_end <= (w_cnt_nxt == CNT_LAST);
    end
  end

  assign o_cnt      = r_cnt;
  assign o_slot_end = r_slot_end;

endmodule

// File: rtl/seg_scan.sv
// Eight-digit multiplexed seven-segment driver with per-slot blanking and per-frame snapshot.
module seg_scan #(
  parameter int unsigned CLK_DIV = 1000,
  parameter int unsigned BLANK   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] i_seg0,
  input  logic [7:0] i_seg1,
  input  logic [7:0] i_seg2,
  input  logic [7:0] i_seg3,
  input  logic [7:0] i_seg4,
  input  logic [7:0] i_seg5,
  input  logic [7:0] i_seg6,
  input  logic [7:0] i_seg7,
  output logic [7:0] o_seg,
  output logic [7:0] o_an,
  output logic       o_frame
);

  import seg_pkg::*;

  localparam int unsigned CW      = $clog2(CLK_DIV);
  localparam bit          HAS_GAP = (BLANK != 0);

  scan_state_e      r_state, w_state_nxt;
  logic [DIG_W-1:0] r_d, w_d_nxt;
  logic [SEG_W-1:0] r_snap [NDIG];
  logic [SEG_W-1:0] w_in   [NDIG];
  scan_out_t        r_out, w_out_nxt;
  logic             w_take_snap;
  logic             w_gap_nxt;
  logic [CW-1:0]    w_cnt;
  logic             w_slot_end;
  logic             w_clr;
  logic             w_adv;

  assign w_in[0] = i_seg0;
  assign w_in[1] = i_seg1;
  assign w_in[2] = i_seg2;
  assign w_in[3] = i_seg3;
  assign w_in[4] = i_seg4;
  assign w_in[5] = i_seg5;
  assign w_in[6] = i_seg6;
  assign w_in[7] = i_seg7;

  // Counter holds at 0 in IDLE so the entry edge is slot cycle 0.
  assign w_clr = !en;
  assign w_adv = (r_state != IDLE);

  seg_slot_cnt #(
    .CLK_DIV (CLK_DIV)
  ) u_slot_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_clr),
    .i_adv      (w_adv),
    .o_cnt      (w_cnt),
    .o_slot_end (w_slot_end)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, digit index, snapshot strobe and output decode for the coming cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_d_nxt         = r_d;
    w_take_snap     = 1'b0;
    w_gap_nxt       = 1'b0;
    w_out_nxt.seg   = SEG_DARK;
    w_out_nxt.an    = AN_OFF;
    w_out_nxt.frame = 1'b0;
    if (!en) begin
      w_state_nxt = IDLE;
      w_d_nxt     = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_d_nxt     = '0;
          w_take_snap = 1'b1;
          w_gap_nxt   = HAS_GAP;
        end
        default: begin
          if (w_slot_end) begin
            w_d_nxt     = r_d + 3'd1;
            w_take_snap = (r_d == DIG_LAST);
            w_gap_nxt   = HAS_GAP;
          end else begin
            // Coming count is w_cnt+1; the frame pulse marks digit 7's last slot cycle.
            w_gap_nxt       = (32'(w_cnt) + 32'd1) < BLANK;
            w_out_nxt.frame = (r_d == DIG_LAST) && ((32'(w_cnt) + 32'd2) == CLK_DIV);
          end
        end
      endcase
      w_state_nxt = w_gap_nxt ? GAP : SHOW;
      if (!w_gap_nxt) begin
        w_out_nxt.an  = an_onehot(w_d_nxt);
        // On the snapshot edge the register is not yet loaded, so bypass from the inputs.
        w_out_nxt.seg = w_take_snap ? w_in[w_d_nxt] : r_snap[w_d_nxt];
      end
    end
  end

  // Digit index, frame snapshot and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d             <= '0;
      r_out.seg       <= SEG_DARK;
      r_out.an        <= AN_OFF;
      r_out.frame     <= 1'b0;
      for (int unsigned i = 0; i < NDIG; i++) begin
        r_snap[i] <= SEG_DARK;
      end
    end else begin
      r_d   <= w_d_nxt;
      r_out <= w_out_nxt;
      if (w_take_snap) begin
        for (int unsigned i = 0; i < NDIG; i++) begin
          r_snap[i] <= w_in[i];
        end
      end
    end
  end

  assign o_seg   = r_out.seg;
  assign o_an    = r_out.an;
  assign o_frame = r_out.frame;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: two configurations against a time-index reference model plus directed vectors.
module tb_seg_scan;

  localparam int unsigned CD0 = 8;
  localparam int unsigned BL0 = 2;
  localparam int unsigned CD1 = 4;
  localparam int unsigned BL1 = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] seg_in [8];
  logic [7:0] an_o   [2];
  logic [7:0] seg_o  [2];
  logic       fr_o   [2];

  int n_pass = 0;
  int n_tot  = 0;
  int e      = -1;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  seg_scan #(.CLK_DIV(CD0), .BLANK(BL0)) u_a (
    .clk(clk), .rst(rst), .en(en),
    .i_seg0(seg_in[0]), .i_seg1(seg_in[1]), .i_seg2(seg_in[2]), .i_seg3(seg_in[3]),
    .i_seg4(seg_in[4]), .i_seg5(seg_in[5]), .i_seg6(seg_in[6]), .i_seg7(seg_in[7]),
    .o_seg(seg_o[0]), .o_an(an_o[0]), .o_frame(fr_o[0])
  );

  seg_scan #(.CLK_DIV(CD1), .BLANK(BL1)) u_b (
    .clk(clk), .rst(rst), .en(en),
    .i_seg0(seg_in[0]), .i_seg1(seg_in[1]), .i_seg2(seg_in[2]), .i_seg3(seg_in[3]),
    .i_seg4(seg_in[4]), .i_seg5(seg_in[5]), .i_seg6(seg_in[6]), .i_seg7(seg_in[7]),
    .o_seg(seg_o[1]), .o_an(an_o[1]), .o_frame(fr_o[1])
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: position is just the number of edges since the scan started.
  int         cd_t [2] = '{int'(CD0), int'(CD1)};
  int         bl_t [2] = '{int'(BL0), int'(BL1)};
  bit         m_run = 1'b0;
  int         m_k   [2];
  logic [7:0] m_snap[2][8];
  logic [7:0] ex_an [2];
  logic [7:0] ex_seg[2];
  logic       ex_fr [2];

  always @(posedge clk or negedge rst) begin
    if (!rst || !en) begin
      m_run = 1'b0;
      for (int i = 0; i < 2; i++) begin
        ex_an[i] = 8'hFF; ex_seg[i] = 8'hFF; ex_fr[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int         flen, pos, dig;
        logic [7:0] one;
        one  = 8'h01;
        m_k[i] = m_run ? m_k[i] + 1 : 0;
        flen = 8 * cd_t[i];
        pos  = m_k[i] % flen;
        dig  = (m_k[i] / cd_t[i]) % 8;
        if (pos == 0) m_snap[i] = seg_in;
        if ((m_k[i] % cd_t[i]) < bl_t[i]) begin
          ex_an[i] = 8'hFF; ex_seg[i] = 8'hFF;
        end else begin
          ex_an[i] = ~(one << dig); ex_seg[i] = m_snap[i][dig];
        end
        ex_fr[i] = (pos == flen - 1);
      end
      m_run = 1'b1;
    end
  end

  // Every-cycle comparison against the model plus the display-safety properties.
  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model_an%0d", i), an_o[i], ex_an[i]);
        chk($sformatf("model_seg%0d", i), seg_o[i], ex_seg[i]);
        chk($sformatf("model_frame%0d", i), 8'(fr_o[i]), 8'(ex_fr[i]));
        chk($sformatf("onehot%0d", i), 8'($countones(~an_o[i]) <= 1), 8'd1);
        if (an_o[i] == 8'hFF) chk($sformatf("dark_seg%0d", i), seg_o[i], 8'hFF);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic go(input int t);
    while (e < t) tick();
  endtask

  typedef struct {
    int         inst;
    int         ed;
    logic [7:0] an;
    logic [7:0] seg;
    logic       fr;
  } vec_t;

  vec_t tbl [17];

  initial begin
    tbl[0]  = '{0, 0,  8'hFF, 8'hFF, 1'b0};
    tbl[1]  = '{1, 0,  8'hFE, 8'h02, 1'b0};
    tbl[2]  = '{0, 1,  8'hFF, 8'hFF, 1'b0};
    tbl[3]  = '{0, 2,  8'hFE, 8'h02, 1'b0};
    tbl[4]  = '{1, 3,  8'hFE, 8'h02, 1'b0};
    tbl[5]  = '{1, 4,  8'hFD, 8'h9F, 1'b0};
    tbl[6]  = '{0, 7,  8'hFE, 8'h02, 1'b0};
    tbl[7]  = '{0, 8,  8'hFF, 8'hFF, 1'b0};
    tbl[8]  = '{1, 8,  8'hFB, 8'h25, 1'b0};
    tbl[9]  = '{0, 9,  8'hFF, 8'hFF, 1'b0};
    tbl[10] = '{0, 10, 8'hFD, 8'h9F, 1'b0};
    tbl[11] = '{1, 28, 8'h7F, 8'h1F, 1'b0};
    tbl[12] = '{1, 31, 8'h7F, 8'h1F, 1'b1};
    tbl[13] = '{1, 32, 8'hFE, 8'h02, 1'b0};
    tbl[14] = '{0, 63, 8'h7F, 8'h1F, 1'b1};
    tbl[15] = '{0, 64, 8'hFF, 8'hFF, 1'b0};
    tbl[16] = '{0, 66, 8'hFE, 8'h02, 1'b0};

    rst = 1'b1;
    en  = 1'b0;
    seg_in = '{8'h02, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F};
    #1 rst = 1'b0;
    #1 chk_on = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_an", an_o[i], 8'hFF);
      chk("reset_seg", seg_o[i], 8'hFF);
      chk("reset_frame", 8'(fr_o[i]), 8'h00);
    end
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    e   = -1;

    // Basic scan in both configurations.
    for (int r = 0; r < 17; r++) begin
      go(tbl[r].ed);
      chk($sformatf("tbl%0d_an", r), an_o[tbl[r].inst], tbl[r].an);
      chk($sformatf("tbl%0d_seg", r), seg_o[tbl[r].inst], tbl[r].seg);
      chk($sformatf("tbl%0d_frame", r), 8'(fr_o[tbl[r].inst]), 8'(tbl[r].fr));
    end

    // Snapshot coherence: a mid-frame change to digit 5 appears only next frame.
    seg_in[5] = 8'h02;
    go(146);
    seg_in[5] = 8'h24;
    go(170);
    chk("snap_old_an", an_o[0], 8'hDF);
    chk("snap_old_seg", seg_o[0], 8'h02);
    go(234);
    chk("snap_new_an", an_o[0], 8'hDF);
    chk("snap_new_seg", seg_o[0], 8'h24);

    // Enable drop during digit 3's SHOW, resume five cycles later with fresh data.
    go(283);
    chk("drop_pre_an", an_o[0], 8'hF7);
    en = 1'b0;
    seg_in[0] = 8'hC0;
    for (int j = 0; j < 5; j++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        chk("drop_an", an_o[i], 8'hFF);
        chk("drop_seg", seg_o[i], 8'hFF);
        chk("drop_frame", 8'(fr_o[i]), 8'h00);
      end
    end
    en = 1'b1;
    e  = -1;
    tick();
    chk("resume_b_an", an_o[1], 8'hFE);
    chk("resume_b_seg", seg_o[1], 8'hC0);
    chk("resume_a_an", an_o[0], 8'hFF);
    go(2);
    chk("resume_a_an2", an_o[0], 8'hFE);
    chk("resume_a_seg2", seg_o[0], 8'hC0);

    // Enable low on the edge that would raise the frame pulse.
    go(30);
    en = 1'b0;
    tick();
    chk("en_vs_frame_fr", 8'(fr_o[1]), 8'h00);
    chk("en_vs_frame_an", an_o[1], 8'hFF);
    en = 1'b1;
    e  = -1;

    // Asynchronous reset mid-scan, then restart from digit 0.
    tick();
    go(31);
    chk("pre_rst_frame", 8'(fr_o[1]), 8'h01);
    #1 rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("async_rst_an", an_o[i], 8'hFF);
      chk("async_rst_seg", seg_o[i], 8'hFF);
      chk("async_rst_frame", 8'(fr_o[i]), 8'h00);
    end
    #1 rst = 1'b1;
    e = -1;
    tick();
    chk("post_rst_b_an", an_o[1], 8'hFE);
    chk("post_rst_b_seg", seg_o[1], 8'hC0);
    chk("post_rst_a_an", an_o[0], 8'hFF);

    // Random data over more than three frames of the slower configuration.
    for (int c = 0; c < 200; c++) begin
      if ($urandom_range(7) == 0) begin
        for (int i = 0; i < 8; i++) seg_in[i] = 8'($urandom);
      end
      tick();
    end

    // Random enable dropouts.
    for (int c = 0; c < 150; c++) begin
      en = ($urandom_range(15) != 0);
      if ($urandom_range(5) == 0) begin
        for (int i = 0; i < 8; i++) seg_in[i] = 8'($urandom);
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
